// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: opcode/funct fields,
// datapath select codes, FSM state encoding and the decoder's result bundle.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_DM   = 2'd1;
  localparam logic [1:0] M2R_PC4  = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;
  localparam logic [2:0] ALU_SLL  = 3'd4;
  localparam logic [2:0] ALU_SRL  = 3'd5;
  localparam logic [2:0] ALU_SRA  = 3'd6;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXE_R, S_WB_ALU, S_EXE_I,
    S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_JR, CLS_ORI, CLS_LUI, CLS_LW, CLS_SW,
    CLS_BEQ, CLS_J, CLS_JAL, CLS_ILL
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] aluop;
    logic [1:0] extop;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction/data memory req-ready handshake between the control FSM
// (master) and the memory system (slave).
interface mc_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decoder: IR opcode/funct to instruction class
// plus the ALU operation and immediate-extension mode that class needs.
module mc_ctrl_dec
  import mips_defs::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign unused_fields = ^instr_i[25:6];

  always_comb begin
    // NOTE: every field gets a default first so no decode path infers a latch.
    dec_o.cls   = CLS_ILL;
    dec_o.aluop = ALU_ADD;
    dec_o.extop = EXT_ZERO;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin dec_o.cls = CLS_R; dec_o.aluop = ALU_ADD; end
          FN_SUBU: begin dec_o.cls = CLS_R; dec_o.aluop = ALU_SUB; end
          FN_SLL:  begin dec_o.cls = CLS_R; dec_o.aluop = ALU_SLL; end
          FN_SRL:  begin dec_o.cls = CLS_R; dec_o.aluop = ALU_SRL; end
          FN_SRA:  begin dec_o.cls = CLS_R; dec_o.aluop = ALU_SRA; end
          FN_JR:   dec_o.cls = CLS_JR;
          default: dec_o.cls = CLS_ILL;
        endcase
      end
      OP_ORI: begin dec_o.cls = CLS_ORI; dec_o.aluop = ALU_OR; end
      OP_LUI: begin dec_o.cls = CLS_LUI; dec_o.aluop = ALU_LUI; end
      OP_LW:  begin dec_o.cls = CLS_LW;  dec_o.extop = EXT_SIGN; end
      OP_SW:  begin dec_o.cls = CLS_SW;  dec_o.extop = EXT_SIGN; end
      OP_BEQ: begin dec_o.cls = CLS_BEQ; dec_o.aluop = ALU_SUB; dec_o.extop = EXT_SIGN; end
      OP_J:   dec_o.cls = CLS_J;
      OP_JAL: dec_o.cls = CLS_JAL;
      default: dec_o.cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: sequences the shared datapath per instruction,
// runs the memory req/ready handshakes and counts retired instructions.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             hold,
  mc_ctrl_if.master        mem,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcwrite_cond,
  output logic [1:0]       npcop,
  output logic             regwrite,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             alusrc,
  output logic [2:0]       aluop,
  output logic [1:0]       extop,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             req_pend_q, req_pend_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             imem_req_c, dmem_req_c, dmem_we_c;
  dec_t             dec;

  mc_ctrl_dec u_dec (
    .instr_i (instr),
    .dec_o   (dec)
  );

  assign mem.imem_req = imem_req_c;
  assign mem.dmem_req = dmem_req_c;
  assign mem.dmem_we  = dmem_we_c;
  assign retired      = retired_q;

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    pcwrite_cond = 1'b0;
    npcop        = NPC_PC4;
    regwrite     = 1'b0;
    regdst       = RD_RT;
    memtoreg     = M2R_ALU;
    alusrc       = 1'b0;
    aluop        = ALU_ADD;
    extop        = EXT_ZERO;
    illegal      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        // Hold only blocks a fresh request; a raised request rides out to ready.
        imem_req_c = ~hold | req_pend_q;
        if (imem_req_c && mem.imem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (dec.cls)
          CLS_R:                state_d = S_EXE_R;
          CLS_JR, CLS_J, CLS_JAL: state_d = S_JUMP;
          CLS_ORI, CLS_LUI:     state_d = S_EXE_I;
          CLS_LW, CLS_SW:       state_d = S_MEM_ADDR;
          CLS_BEQ:              state_d = S_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_EXE_R: begin
        aluop   = dec.aluop;
        state_d = S_WB_ALU;
      end

      S_EXE_I: begin
        alusrc  = 1'b1;
        aluop   = dec.aluop;
        extop   = dec.extop;
        state_d = S_WB_ALU;
      end

      S_WB_ALU: begin
        alusrc   = (dec.cls != CLS_R);
        aluop    = dec.aluop;
        extop    = dec.extop;
        regwrite = 1'b1;
        regdst   = (dec.cls == CLS_R) ? RD_RD : RD_RT;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_ADDR: begin
        alusrc  = 1'b1;
        extop   = EXT_SIGN;
        state_d = (dec.cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        dmem_req_c = 1'b1;
        if (mem.dmem_ready) state_d = S_WB_MEM;
      end

      S_WB_MEM: begin
        regwrite = 1'b1;
        memtoreg = M2R_DM;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WR: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = 1'b1;
        if (mem.dmem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_BRANCH: begin
        aluop        = ALU_SUB;
        pcwrite_cond = 1'b1;
        npcop        = NPC_BR;
        extop        = EXT_SIGN;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        pcwrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (dec.cls)
          CLS_JR:  npcop = NPC_JR;
          CLS_JAL: begin
            npcop    = NPC_JMP;
            regwrite = 1'b1;
            regdst   = RD_RA;
            memtoreg = M2R_PC4;
          end
          default: npcop = NPC_JMP;
        endcase
      end

      default: state_d = S_IDLE;
    endcase

    req_pend_d = (state_q == S_FETCH) && imem_req_c && !mem.imem_ready;
  end

  // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_pend_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_pend_q <= req_pend_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-instruction vector table with a small
// memory responder, plus hand sequences for hold and mid-instruction reset.
module tb_mc_ctrl;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] instr = '0;
  logic        irwrite, pcwrite, pcwrite_cond, regwrite, alusrc, illegal;
  logic [1:0]  npcop, regdst, memtoreg, extop;
  logic [2:0]  aluop;
  logic [31:0] retired;

  mc_ctrl_if mem ();

  mc_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .instr        (instr),
    .hold         (hold),
    .mem          (mem),
    .irwrite      (irwrite),
    .pcwrite      (pcwrite),
    .pcwrite_cond (pcwrite_cond),
    .npcop        (npcop),
    .regwrite     (regwrite),
    .regdst       (regdst),
    .memtoreg     (memtoreg),
    .alusrc       (alusrc),
    .aluop        (aluop),
    .extop        (extop),
    .illegal      (illegal),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwrite_cond;
    logic [1:0] npcop;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrc;
    logic [2:0] aluop;
    logic [1:0] extop;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    int          iwait;
    int          dwait;
    int          cycles;
    int          dreqs;
    int          ret_inc;
    out_t        last;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_ret = '0;
  vec_t        vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t snap();
    return {mem.imem_req, mem.dmem_req, mem.dmem_we, irwrite, pcwrite, pcwrite_cond,
            npcop, regwrite, regdst, memtoreg, alusrc, aluop, extop, illegal};
  endfunction

  function automatic out_t o(logic dreq, logic we, logic pcw, logic pcc, logic [1:0] npc,
                             logic rw, logic [1:0] rd, logic [1:0] m2r, logic as,
                             logic [2:0] op, logic [1:0] ex, logic ill);
    return {1'b0, dreq, we, 1'b0, pcw, pcc, npc, rw, rd, m2r, as, op, ex, ill};
  endfunction

  // Runs one instruction starting in FETCH; responds to requests after the
  // vector's wait counts and records the outputs of the final state.
  task automatic run_vec(input vec_t v, input int idx);
    int   iw, dw, cyc, dreqs;
    bit   left, done;
    out_t cur, last;
    iw = 0; dw = 0; cyc = 0; dreqs = 0; left = 0; done = 0; last = '0;
    instr = v.instr;
    while (!done && cyc < 60) begin
      mem.imem_ready = mem.imem_req && (iw >= v.iwait);
      mem.dmem_ready = mem.dmem_req && (dw >= v.dwait);
      #1;
      cur = snap();
      if (cyc > 0 && left && cur.imem_req) begin
        done = 1;
        mem.imem_ready = 1'b0;
        mem.dmem_ready = 1'b0;
      end else begin
        if (!cur.imem_req) left = 1;
        if (cur.imem_req) iw++;
        if (cur.dmem_req) begin dw++; dreqs++; end
        last = cur;
        cyc++;
        @(negedge clk);
      end
    end
    exp_ret = exp_ret + v.ret_inc;
    check($sformatf("v%0d %h completes", idx, v.instr), done, 1);
    check($sformatf("v%0d %h cycles", idx, v.instr), cyc, v.cycles);
    check($sformatf("v%0d %h dmem_req cycles", idx, v.instr), dreqs, v.dreqs);
    check($sformatf("v%0d %h final outputs", idx, v.instr), last, v.last);
    check($sformatf("v%0d %h retired", idx, v.instr), retired, exp_ret);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;

    //            instr         iw dw cyc dreq ret  final-state outputs
    vecs[0]  = '{32'h00221821, 0, 0, 4, 0, 1, o(0,0,0,0,0,1,1,0,0,0,0,0)}; // addu
    vecs[1]  = '{32'h00221821, 2, 0, 6, 0, 1, o(0,0,0,0,0,1,1,0,0,0,0,0)}; // addu, fetch waits
    vecs[2]  = '{32'h00221823, 0, 0, 4, 0, 1, o(0,0,0,0,0,1,1,0,0,1,0,0)}; // subu
    vecs[3]  = '{32'h00021900, 0, 0, 4, 0, 1, o(0,0,0,0,0,1,1,0,0,4,0,0)}; // sll
    vecs[4]  = '{32'h00021902, 0, 0, 4, 0, 1, o(0,0,0,0,0,1,1,0,0,5,0,0)}; // srl
    vecs[5]  = '{32'h00021903, 0, 0, 4, 0, 1, o(0,0,0,0,0,1,1,0,0,6,0,0)}; // sra
    vecs[6]  = '{32'h34221234, 1, 0, 5, 0, 1, o(0,0,0,0,0,1,0,0,1,2,0,0)}; // ori
    vecs[7]  = '{32'h3C02ABCD, 0, 0, 4, 0, 1, o(0,0,0,0,0,1,0,0,1,3,0,0)}; // lui
    vecs[8]  = '{32'h8C220008, 0, 3, 8, 4, 1, o(0,0,0,0,0,1,0,1,0,0,0,0)}; // lw, 3 waits
    vecs[9]  = '{32'h8C220008, 0, 0, 5, 1, 1, o(0,0,0,0,0,1,0,1,0,0,0,0)}; // lw
    vecs[10] = '{32'hAC220008, 0, 0, 4, 1, 1, o(1,1,0,0,0,0,0,0,0,0,0,0)}; // sw
    vecs[11] = '{32'hAC220008, 0, 2, 6, 3, 1, o(1,1,0,0,0,0,0,0,0,0,0,0)}; // sw, 2 waits
    vecs[12] = '{32'h10220004, 0, 0, 3, 0, 1, o(0,0,0,1,1,0,0,0,0,1,1,0)}; // beq
    vecs[13] = '{32'h08000010, 0, 0, 3, 0, 1, o(0,0,1,0,2,0,0,0,0,0,0,0)}; // j
    vecs[14] = '{32'h0C000010, 0, 0, 3, 0, 1, o(0,0,1,0,2,1,2,2,0,0,0,0)}; // jal
    vecs[15] = '{32'h03E00008, 0, 0, 3, 0, 1, o(0,0,1,0,3,0,0,0,0,0,0,0)}; // jr
    vecs[16] = '{32'hFC000000, 0, 0, 2, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1)}; // opcode 111111
    vecs[17] = '{32'h00221827, 0, 0, 2, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,1)}; // nor: bad funct

    mem.imem_ready = 1'b0;
    mem.dmem_ready = 1'b0;

    #1;
    check("reset outputs", snap(), '0);
    check("reset retired", retired, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle outputs", snap(), '0);
    @(negedge clk);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Hold before any request: nothing is raised and a stray ready is ignored.
    hold = 1'b1;
    #1;
    check("hold blocks req", mem.imem_req, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem.imem_ready = 1'b1;
      #1;
      check($sformatf("hold idle c%0d req/irwrite", i), {mem.imem_req, irwrite}, 2'b00);
    end
    mem.imem_ready = 1'b0;
    hold = 1'b0;
    #1;
    check("req after hold drop", mem.imem_req, 1);

    // Hold raised once the request is outstanding: request must persist.
    @(negedge clk);
    hold = 1'b1;
    #1;
    check("req held under hold", mem.imem_req, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("req held c%0d", i), mem.imem_req, 1);
    end
    instr = 32'h00221821;
    mem.imem_ready = 1'b1;
    #1;
    check("held fetch accepted", {irwrite, pcwrite}, 2'b11);
    @(negedge clk);
    mem.imem_ready = 1'b0;
    hold = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      #1;
      if (mem.imem_req) seen = 1;
      else begin n++; @(negedge clk); end
    end
    exp_ret = exp_ret + 1;
    check("held instr returns to fetch", seen, 1);
    check("held instr cycles after fetch", n, 3);
    check("held instr retired", retired, exp_ret);

    // Reset while waiting on a data read.
    instr = 32'h8C220008;
    mem.imem_ready = 1'b1;
    @(negedge clk);
    mem.imem_ready = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 6) begin
      #1;
      if (mem.dmem_req) seen = 1;
      else begin n++; @(negedge clk); end
    end
    check("reached MEM_RD", seen, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-read reset outputs", snap(), '0);
    check("mid-read reset retired", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-release idle", snap(), '0);
    @(negedge clk);
    #1;
    check("fetch one cycle after release", mem.imem_req, 1);
    check("retired stays 0", retired, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
